// File: rtl/cpu_loader.sv
// cpu_loader: loads IMEM/DMEM from a word stream, runs the core, then dumps state after halt.
// Optional LOADER_DMEM_DUMP_EN appends the full data memory to the dump.
module cpu_loader #(
  parameter int DATA_W = 16,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int NREGS = 8,
  localparam int ADDR_W = $clog2(IMEM_DEPTH > DMEM_DEPTH ? IMEM_DEPTH : DMEM_DEPTH),
  localparam int RIDX_W = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              go,
  output logic              cpu_rst_n,
  input  logic              do_halt,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [RIDX_W-1:0] reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
`ifdef LOADER_DMEM_DUMP_EN
  output logic [ADDR_W-1:0] dmem_raddr,
  input  logic [DATA_W-1:0] dmem_rdata,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              wrap_err,
  output logic              done
);
`ifdef LOADER_DMEM_DUMP_EN
  localparam int NWORDS = NREGS + DMEM_DEPTH;
`else
  localparam int NWORDS = NREGS;
`endif
  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [2:0] HDR = 3'd0, LOAD = 3'd1, RUN = 3'd2, DUMP = 3'd3, DONE = 3'd4;
  logic [2:0] state_q, state_d;
  logic tgt_q, tgt_d, wrap_q, wrap_d, cur_q, prev_q;
  logic [ADDR_W-1:0] addr_q, addr_d, mask, hdr_mask;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic last_word;
  assign mask = tgt_q ? ADDR_W'(DMEM_DEPTH-1) : ADDR_W'(IMEM_DEPTH-1);
  assign hdr_mask = in_data[DATA_W-1] ? ADDR_W'(DMEM_DEPTH-1) : ADDR_W'(IMEM_DEPTH-1);
  assign in_ready = state_q == HDR || state_q == LOAD;
  assign cpu_rst_n = !in_ready;
  assign imem_we = state_q == LOAD && in_valid && !tgt_q;
  assign dmem_we = state_q == LOAD && in_valid && tgt_q;
  assign mem_addr = addr_q;
  assign mem_wdata = state_q == LOAD ? in_data : '0;
  assign out_valid = state_q == DUMP;
  assign last_word = idx_q == IDX_W'(NWORDS-1);
  assign out_last = out_valid && last_word;
  assign done = state_q == DONE;
  assign wrap_err = wrap_q;
  assign reg_raddr = RIDX_W'(idx_q);
`ifdef LOADER_DMEM_DUMP_EN
  assign dmem_raddr = ADDR_W'(idx_q - IDX_W'(NREGS));
  assign out_data = idx_q >= IDX_W'(NREGS) ? dmem_rdata : reg_rdata;
`else
  assign out_data = reg_rdata;
`endif
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    addr_d = addr_q;
    wrap_d = wrap_q;
    idx_d = idx_q;
    case (state_q)
      HDR: begin
        // a header with in_last is dropped; a header beats a simultaneous go
        if (in_valid) begin
          state_d = in_last ? HDR : LOAD;
          tgt_d = in_last ? tgt_q : in_data[DATA_W-1];
          addr_d = in_last ? addr_q : in_data[ADDR_W-1:0] & hdr_mask;
        end else if (go) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (in_valid) begin
          addr_d = (addr_q + 1'b1) & mask;
          wrap_d = wrap_q | (addr_q == mask);
          state_d = in_last ? HDR : LOAD;
        end
      end
      RUN: begin
        if (prev_q && !cur_q) begin
          state_d = DUMP;
          idx_d = '0;
        end
      end
      DUMP: begin
        if (out_ready) begin
          state_d = last_word ? DONE : DUMP;
          idx_d = last_word ? idx_q : idx_q + 1'b1;
        end
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= HDR;
      tgt_q <= 1'b0;
      addr_q <= '0;
      wrap_q <= 1'b0;
      idx_q <= '0;
      cur_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      addr_q <= addr_d;
      wrap_q <= wrap_d;
      idx_q <= idx_d;
      cur_q <= do_halt;
      prev_q <= cur_q;
    end
  end
endmodule

// File: tb/tb_cpu_loader.sv
// tb_cpu_loader: directed checks of load, wrap, run/halt, dump with backpressure and async reset.
module tb_cpu_loader;
  logic CLK = 1'b0, rst = 1'b0;
  logic in_valid, in_ready, in_last, go, cpu_rst_n, do_halt;
  logic [15:0] in_data, mem_wdata, reg_rdata, out_data;
  logic imem_we, dmem_we, out_valid, out_ready, out_last, wrap_err, done;
  logic [7:0] mem_addr;
  logic [2:0] reg_raddr;
  logic [15:0] regs [8];
  int errs = 0, checks = 0;
`ifdef LOADER_DMEM_DUMP_EN
  logic [7:0] dmem_raddr;
  logic [15:0] dmem_rdata;
  assign dmem_rdata = {8'hD0, dmem_raddr};
`endif
  always #5 CLK = ~CLK;
  assign reg_rdata = regs[reg_raddr];
  cpu_loader #(.DATA_W(16), .IMEM_DEPTH(4), .DMEM_DEPTH(256), .NREGS(8)) dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .go(go), .cpu_rst_n(cpu_rst_n), .do_halt(do_halt),
    .imem_we(imem_we), .dmem_we(dmem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
`ifdef LOADER_DMEM_DUMP_EN
    .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .wrap_err(wrap_err), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge CLK);
  endtask
  task automatic drive(input logic [15:0] d, input logic l);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    #1;
  endtask
  initial begin
    in_valid = 0; in_data = 0; in_last = 0; go = 0; do_halt = 0; out_ready = 0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);
    regs[1] = 16'd245;
    regs[2] = 16'd29890;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 16'h1000);
    chk("rst_reg_raddr", reg_raddr, 0);
    chk("rst_wrap_err", wrap_err, 0);
    chk("rst_done", done, 0);
    tick();
    rst = 1;
    drive(16'h0001, 0);
    chk("ihdr_nowrite", imem_we, 0);
    tick();
    drive(16'h5101, 0);
    chk("i0_we", imem_we, 1);
    chk("i0_dwe", dmem_we, 0);
    chk("i0_addr", mem_addr, 1);
    chk("i0_data", mem_wdata, 16'h5101);
    tick();
    drive(16'hFFFF, 1);
    chk("i1_we", imem_we, 1);
    chk("i1_addr", mem_addr, 2);
    chk("i1_data", mem_wdata, 16'hFFFF);
    tick();
    in_valid = 0;
    #1;
    chk("idle_we", imem_we, 0);
    chk("idle_cpu_rst_n", cpu_rst_n, 0);
    drive(16'h8000, 0);
    chk("dhdr_nowrite", dmem_we, 0);
    tick();
    drive(16'd30000, 0);
    chk("d0_we", dmem_we, 1);
    chk("d0_iwe", imem_we, 0);
    chk("d0_addr", mem_addr, 0);
    chk("d0_data", mem_wdata, 16'd30000);
    tick();
    drive(16'd10, 1);
    chk("d1_we", dmem_we, 1);
    chk("d1_addr", mem_addr, 1);
    chk("d1_data", mem_wdata, 16'd10);
    tick();
    drive(16'h8005, 1);
    chk("drop_nowrite", dmem_we, 0);
    tick();
    drive(16'h0003, 0);
    chk("whdr_nowrite", imem_we, 0);
    tick();
    drive(16'h1111, 0);
    chk("w0_addr", mem_addr, 3);
    chk("w0_we", imem_we, 1);
    chk("w0_wrap", wrap_err, 0);
    tick();
    drive(16'h2222, 1);
    chk("w1_addr", mem_addr, 0);
    chk("w1_we", imem_we, 1);
    chk("w1_wrap", wrap_err, 1);
    tick();
    drive(16'h0000, 0);
    go = 1;
    #1;
    chk("coll_nowrite", imem_we, 0);
    tick();
    in_valid = 0;
    go = 0;
    #1;
    chk("coll_cpu_rst_n", cpu_rst_n, 0);
    chk("coll_in_ready", in_ready, 1);
    drive(16'h0ABC, 1);
    chk("coll_load_we", imem_we, 1);
    chk("coll_load_addr", mem_addr, 0);
    tick();
    in_valid = 0;
    go = 1;
    #1;
    chk("go_pre", cpu_rst_n, 0);
    tick();
    go = 0;
    #1;
    chk("go_cpu_rst_n", cpu_rst_n, 1);
    chk("run_in_ready", in_ready, 0);
    chk("run_sticky_wrap", wrap_err, 1);
    out_ready = 1;
    do_halt = 1;
    tick();
    tick();
    do_halt = 0;
    tick();
    #1;
    chk("halt_lat1", out_valid, 0);
    tick();
    #1;
    chk("halt_lat2", out_valid, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        out_ready = 0;
        repeat (3) begin
          #1;
          chk("hold_data", out_data, regs[3]);
          chk("hold_raddr", reg_raddr, 3);
          chk("hold_last", out_last, 0);
          tick();
        end
        out_ready = 1;
      end
      #1;
      chk("dump_valid", out_valid, 1);
      chk("dump_data", out_data, regs[i]);
      chk("dump_raddr", reg_raddr, 32'(i));
      chk("dump_last", out_last, i == 7 ? 1 : 0);
      chk("dump_done", done, 0);
      tick();
    end
    #1;
    chk("done", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_cpu_rst_n", cpu_rst_n, 1);
    rst = 0;
    #1;
    chk("rst2_done", done, 0);
    chk("rst2_cpu_rst_n", cpu_rst_n, 0);
    tick();
    rst = 1;
    go = 1;
    tick();
    go = 0;
    do_halt = 1;
    tick();
    tick();
    do_halt = 0;
    tick();
    tick();
    #1;
    chk("dump2_valid", out_valid, 1);
    out_ready = 0;
    #2;
    rst = 0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_cpu_rst_n", cpu_rst_n, 0);
    chk("async_in_ready", in_ready, 1);
    tick();
    rst = 1;
    drive(16'h0002, 0);
    chk("post_hdr_nowrite", imem_we, 0);
    tick();
    drive(16'h7777, 1);
    chk("post_we", imem_we, 1);
    chk("post_addr", mem_addr, 2);
    chk("post_data", mem_wdata, 16'h7777);
    tick();
    in_valid = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cpu_loader.md
# cpu_loader

Program loader and post-halt state dumper for the CPU core. Before the CPU runs, it accepts a word stream and writes it into instruction and data memory through dedicated write ports, holding the core in reset. After `go`, it releases the core, waits for the halt indication on `do_halt`, then streams the register file (and optionally data memory) out over a valid/ready port. This replaces hard-coded bench preloading and end-of-run hierarchical peeks with a synthesizable, depth- and width-parametrised block.

## Interface
- `DATA_W`, 16: memory and register word width.
- `IMEM_DEPTH`, 256: instruction memory words, power of two.
- `DMEM_DEPTH`, 256: data memory words, power of two.
- `NREGS`, 8: register file entries, power of two.
- Derived: `ADDR_W = $clog2(max(IMEM_DEPTH, DMEM_DEPTH))`, `RIDX_W = $clog2(NREGS)`. Requires `ADDR_W <= DATA_W-1`.

Ports:
- `CLK` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1, `in_ready` out 1, `in_data` in DATA_W, `in_last` in 1: load stream.
- `go` in 1: start execution.
- `cpu_rst_n` out 1: reset to the CPU core, active-low.
- `do_halt` in 1: CPU halt indication; a halt is a 1→0 transition.
- `imem_we` out 1, `dmem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: memory write port.
- `reg_raddr` out RIDX_W, `reg_rdata` in DATA_W: combinational register read port.
- `dmem_raddr` out ADDR_W, `dmem_rdata` in DATA_W: combinational data memory read port. Present only with `LOADER_DMEM_DUMP_EN`.
- `out_valid` out 1, `out_ready` in 1, `out_data` out DATA_W, `out_last` out 1: dump stream.
- `wrap_err` out 1: sticky flag, load address wrapped.
- `done` out 1: dump complete.

## Operation
- States: HDR, LOAD, RUN, DUMP, DONE. Reset enters HDR.
- HDR:
  - `in_ready=1`.
  - A handshake latches a header word. `in_data[DATA_W-1]` selects the target: 0 = IMEM, 1 = DMEM. `in_data[ADDR_W-1:0]` is the start address. Then go to LOAD.
  - If `in_last` is set on a header, the header is dropped and the state stays HDR.
- LOAD:
  - `in_ready=1`.
  - Each handshake writes `in_data` to the current address. `imem_we` or `dmem_we` is combinational, equal to the handshake, and only the selected strobe fires.
  - The address then increments modulo the target depth. Wrapping from depth-1 to 0 sets `wrap_err`.
  - A handshake with `in_last` performs its write, then returns to HDR.
- In HDR with `go=1` and no handshake, go to RUN. If a header handshake and `go` occur in the same cycle, the header wins and `go` is ignored. `go` is ignored in all other states.
- RUN:
  - `cpu_rst_n=1`, `in_ready=0`.
  - `do_halt` is registered (previous value resets to 0). The prev=1 and cur=0 condition moves to DUMP with index 0.
- DUMP:
  - `out_valid=1`.
  - `out_data = reg_rdata` with `reg_raddr = index`.
  - On `out_valid & out_ready`, the index increments.
  - `out_last` is set on index NREGS-1 (or the final DMEM word with the macro). The handshake on `out_last` moves to DONE.
- DONE: `done=1` and `out_valid=0`. Exit is by reset only.
- `cpu_rst_n=0` in HDR and LOAD, 1 in RUN, DUMP and DONE.

## Timing
- Reset values:
  - `in_ready=1`, `cpu_rst_n=0`.
  - `imem_we=0`, `dmem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `out_valid=0`, `out_last=0`, `out_data=reg_rdata` (index 0).
  - `wrap_err=0`, `done=0`, `reg_raddr=0`.
- Reset asserted mid-operation asynchronously returns to HDR and drops `cpu_rst_n` immediately.
- Write latency: 0 cycles from the data handshake. The header handshake itself never writes.
- `go` to `cpu_rst_n` rising: 1 cycle.
- Halt edge to first `out_valid`: 2 cycles after the `do_halt` fall (1 cycle edge register, 1 cycle state change).
- While `out_ready=0`, `out_data`, `out_last` and the index are held stable.
- `wrap_err` clears only on reset.

## Configuration
- `LOADER_DMEM_DUMP_EN`:
  - Defined: after the NREGS register words, DUMP continues with DMEM_DEPTH words from data memory. `dmem_raddr` = index−NREGS and `out_data = dmem_rdata`. `out_last` is on the final DMEM word.
  - Undefined: the DMEM read ports are absent, and the dump is NREGS words only.

## Test plan
- Load IMEM: header 0x0001, then 0x5101, then 0xFFFF with `in_last` → `imem_we` pulses at `mem_addr` 1 then 2 with those data; `dmem_we` stays 0; state returns to HDR.
- Load DMEM: header 0x8000, then 30000, then 10 with `in_last` → `dmem_we` at addr 0 = 30000 and addr 1 = 10.
- Wrap, with IMEM_DEPTH=4: header 0x0003, then two words → writes at addr 3 then 0; `wrap_err=1`.
- Run/dump: `go` → `cpu_rst_n` high next cycle. Drive `do_halt` 1→0 with a reg model where regs[1]=245 and regs[2]=29890 → 8 words out; word 1 = 245, word 2 = 29890; `out_last` on word 7; then `done=1`.
- Backpressure and collision: `out_ready` low 3 cycles mid-dump → data held. `go` with a simultaneous header handshake → header taken, `cpu_rst_n` stays 0.
- Reset during DUMP → `out_valid=0` and `cpu_rst_n=0` asynchronously; HDR after release.
